// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : task_dispatcher
// Description : Scans published task words, dispatches the highest-priority
//               ready task on the op bus and times its execution slice.
// Revision    : 1.0
// ============================================================================
module task_dispatcher #(
    parameter int N_TASKS      = 8,
    parameter int SLICE_CYCLES = 1000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic [16*N_TASKS-1:0]  in_tasks,
    input  logic [N_TASKS-1:0]     in_exe_flags,
    output logic [15:0]            out_op,
    output logic [7:0]             cur_id,
    output logic                   busy,
    output logic                   ack_err,
    output logic [15:0]            dispatch_count
);

    localparam int c_IW = $clog2(N_TASKS);
    localparam int c_WW = $clog2(ACK_TIMEOUT + 1);
    localparam int c_SW = $clog2(SLICE_CYCLES + 1);
    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(N_TASKS - 1);
    localparam logic [c_WW-1:0] c_WAIT_LAST  = c_WW'(ACK_TIMEOUT - 1);
    localparam logic [c_SW-1:0] c_SLICE_LAST = c_SW'(SLICE_CYCLES - 1);
    localparam logic [3:0]      c_OP_EXEC    = 4'b0111;
    localparam logic [3:0]      c_OP_FIN     = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ISSUE  = 3'd2,
        S_ACK    = 3'd3,
        S_RUN    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t           r_state;
    logic [c_IW-1:0]  r_idx;
    logic             r_have;
    logic [7:0]       r_best_id;
    logic [7:0]       r_best_pri;
    logic [c_IW-1:0]  r_best_idx;
    logic [c_WW-1:0]  r_wait;
    logic [c_SW-1:0]  r_slice;
    logic             r_acked;

    logic [15:0]      w_slot;
    logic             w_take;
    logic             w_nb_have;
    logic [7:0]       w_nb_id;
    logic [7:0]       w_nb_pri;
    logic [c_IW-1:0]  w_nb_idx;

    // Strictly-greater replacement leaves ties with the lower index.
    assign w_slot    = in_tasks[16*int'(r_idx) +: 16];
    assign w_take    = (w_slot[15:8] != 8'd0) && (!r_have || (w_slot[7:0] > r_best_pri));
    assign w_nb_have = r_have | w_take;
    assign w_nb_id   = w_take ? w_slot[15:8] : r_best_id;
    assign w_nb_pri  = w_take ? w_slot[7:0]  : r_best_pri;
    assign w_nb_idx  = w_take ? r_idx        : r_best_idx;

    assign busy = (r_state != S_IDLE) && (r_state != S_SCAN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_have         <= 1'b0;
            r_best_id      <= 8'd0;
            r_best_pri     <= 8'd0;
            r_best_idx     <= '0;
            r_wait         <= '0;
            r_slice        <= '0;
            r_acked        <= 1'b0;
            out_op         <= 16'h0000;
            cur_id         <= 8'd0;
            ack_err        <= 1'b0;
            dispatch_count <= 16'd0;
        end else begin
            // Ops are loaded on entry to ISSUE/FINISH, so they last one cycle.
            out_op <= 16'h0000;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_have     <= 1'b0;
                        r_best_id  <= 8'd0;
                        r_best_pri <= 8'd0;
                        r_best_idx <= '0;
                        r_idx      <= '0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_have     <= w_nb_have;
                    r_best_id  <= w_nb_id;
                    r_best_pri <= w_nb_pri;
                    r_best_idx <= w_nb_idx;
                    if (r_idx == c_LAST_IDX) begin
                        if (w_nb_have) begin
                            out_op  <= {4'h0, w_nb_id[3:0], c_OP_EXEC, 4'h0};
                            cur_id  <= w_nb_id;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wait  <= '0;
                    r_acked <= 1'b0;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (in_exe_flags[r_best_idx]) begin
                        r_slice <= '0;
                        r_acked <= 1'b1;
                        r_state <= S_RUN;
                    end else if (r_wait == c_WAIT_LAST) begin
                        ack_err <= 1'b1;
                        out_op  <= {4'h0, r_best_id[3:0], c_OP_FIN, 4'h0};
                        r_state <= S_FINISH;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_slice == c_SLICE_LAST) begin
                        out_op  <= {4'h0, r_best_id[3:0], c_OP_FIN, 4'h0};
                        r_state <= S_FINISH;
                    end else begin
                        r_slice <= r_slice + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (r_acked) begin
                        dispatch_count <= dispatch_count + 16'd1;
                    end
                    cur_id  <= 8'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_dispatcher
// Description : Randomized self-checking bench for task_dispatcher against a
//               round-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_task_dispatcher;

    localparam int N_TASKS      = 8;
    localparam int SLICE_CYCLES = 20;
    localparam int ACK_TIMEOUT  = 16;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  enable;
    logic [16*N_TASKS-1:0] in_tasks;
    logic [N_TASKS-1:0]    in_exe_flags;
    logic [15:0]           out_op;
    logic [7:0]            cur_id;
    logic                  busy;
    logic                  ack_err;
    logic [15:0]           dispatch_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_err = 1'b0;
    logic [15:0] plan [N_TASKS];

    task_dispatcher #(
        .N_TASKS     (N_TASKS),
        .SLICE_CYCLES(SLICE_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (enable),
        .in_tasks      (in_tasks),
        .in_exe_flags  (in_exe_flags),
        .out_op        (out_op),
        .cur_id        (cur_id),
        .busy          (busy),
        .ack_err       (ack_err),
        .dispatch_count(dispatch_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] gen_slot();
        logic [7:0] id;
        logic [7:0] pri;
        if ($urandom_range(0, 9) < 4) return 16'h0000;
        id  = 8'($urandom_range(1, 255));
        pri = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
        return {id, pri};
    endfunction

    task automatic clear_plan();
        for (int s = 0; s < N_TASKS; s++) plan[s] = 16'h0000;
    endtask

    // One dispatch round, starting and ending with the DUT idle.
    task automatic run_round(input bit use_plan, input int ack_at, input int rst_run, input int gap);
        logic [15:0]        seen [N_TASKS];
        logic [15:0]        w;
        logic [7:0]         bid;
        logic [N_TASKS-1:0] sel;
        int                 best;
        bit                 acked;

        enable = 1'b0;
        for (int g = 0; g < gap; g++) begin
            for (int s = 0; s < N_TASKS; s++) in_tasks[16*s +: 16] = gen_slot();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_op", 32'(out_op), 32'h0);
            tick();
        end
        enable = 1'b1;
        tick();
        for (int k = 0; k < N_TASKS; k++) begin
            for (int s = 0; s < N_TASKS; s++) begin
                w = use_plan ? plan[s] : gen_slot();
                in_tasks[16*s +: 16] = w;
                if (s == k) seen[k] = w;
            end
            chk("scan_busy", 32'(busy), 32'd0);
            chk("scan_op", 32'(out_op), 32'h0);
            tick();
        end

        best = -1;
        for (int k = 0; k < N_TASKS; k++) begin
            if (seen[k][15:8] != 8'd0 && (best < 0 || seen[k][7:0] > seen[best][7:0])) best = k;
        end
        if (best < 0) begin
            chk("noready_op", 32'(out_op), 32'h0);
            chk("noready_busy", 32'(busy), 32'd0);
            return;
        end
        bid = seen[best][15:8];
        sel = N_TASKS'(1) << best;
        chk("exec_op", 32'(out_op), {16'h0, 4'h0, bid[3:0], 4'h7, 4'h0});
        chk("exec_cur_id", 32'(cur_id), 32'(bid));
        chk("exec_busy", 32'(busy), 32'd1);
        for (int s = 0; s < N_TASKS; s++) in_tasks[16*s +: 16] = gen_slot();
        tick();

        acked = 1'b0;
        for (int j = 0; j < ACK_TIMEOUT; j++) begin
            enable       = 1'($urandom_range(0, 1));
            in_exe_flags = (N_TASKS'($urandom) & ~sel) | ((j == ack_at) ? sel : '0);
            chk("ack_op", 32'(out_op), 32'h0);
            chk("ack_busy", 32'(busy), 32'd1);
            tick();
            if (j == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        in_exe_flags = N_TASKS'($urandom);

        if (acked) begin
            for (int r = 0; r < SLICE_CYCLES; r++) begin
                if (r == rst_run) begin
                    RST = 1'b1;
                    #1;
                    chk("rst_op", 32'(out_op), 32'h0);
                    chk("rst_cur_id", 32'(cur_id), 32'h0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_ack_err", 32'(ack_err), 32'd0);
                    chk("rst_count", 32'(dispatch_count), 32'd0);
                    tick();
                    RST   = 1'b0;
                    m_cnt = 16'd0;
                    m_err = 1'b0;
                    return;
                end
                chk("run_op", 32'(out_op), 32'h0);
                chk("run_cur_id", 32'(cur_id), 32'(bid));
                tick();
            end
        end else begin
            m_err = 1'b1;
        end

        chk("fin_op", 32'(out_op), {16'h0, 4'h0, bid[3:0], 4'hF, 4'h0});
        chk("fin_ack_err", 32'(ack_err), 32'(m_err));
        if (acked) m_cnt = m_cnt + 16'd1;
        tick();
        chk("post_op", 32'(out_op), 32'h0);
        chk("post_cur_id", 32'(cur_id), 32'h0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_count", 32'(dispatch_count), 32'(m_cnt));
        chk("post_ack_err", 32'(ack_err), 32'(m_err));
    endtask

    initial begin
        RST          = 1'b1;
        enable       = 1'b0;
        in_tasks     = '0;
        in_exe_flags = '0;
        tick();
        tick();
        chk("reset_op", 32'(out_op), 32'h0);
        chk("reset_cur_id", 32'(cur_id), 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack_err", 32'(ack_err), 32'd0);
        chk("reset_count", 32'(dispatch_count), 32'd0);
        RST = 1'b0;
        tick();

        clear_plan();
        plan[3] = 16'h0507;
        plan[6] = 16'h0203;
        run_round(1'b1, 0, -1, 0);

        clear_plan();
        plan[1] = 16'h0404;
        plan[5] = 16'h0604;
        run_round(1'b1, -1, -1, 0);

        clear_plan();
        for (int i = 0; i < 11; i++) run_round(1'b1, -1, -1, 0);

        for (int i = 0; i < 40; i++) begin
            run_round(1'b0, int'($urandom_range(0, 20)), -1, int'($urandom_range(0, 3)));
        end

        clear_plan();
        plan[3] = 16'h0507;
        plan[6] = 16'h0203;
        run_round(1'b1, 2, 5, 1);

        clear_plan();
        plan[1] = 16'h0404;
        plan[5] = 16'h0604;
        run_round(1'b1, 1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/task_dispatcher.md
# task_dispatcher

Downstream stage of the per-task blocks in the hardware scheduler. It scans the `{id, priority}` words that every task instance publishes, picks the highest-priority ready task, and broadcasts the 16-bit Execute operation on the shared op bus. It then waits for that task's `exe_flag`, holds it for a fixed time slice, and closes the slice with a Finish-execution operation. It is the only driver of the tasks' `in_op` bus.

## Interface
- `N_TASKS`, default 8: number of task instances scanned (2..16).
- `SLICE_CYCLES`, default 1000: cycles a task holds the CPU after acknowledging Execute (≥1).
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for the selected task's `exe_flag` (≥1).
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, no new dispatch starts; a slice already in progress completes.
- `in_tasks`  in  16*N_TASKS  packed task words; slot k occupies bits [16k+15:16k]: [15:8] task id, [7:0] priority; an all-zero slot means not ready.
- `in_exe_flags`  in  N_TASKS  `exe_flag` of each task, one bit per slot.
- `out_op`  out  16  op bus to every task's `in_op`: [15:12]=0, [11:8]=id[3:0], [7:4]=opcode, [3:0]=0.
- `cur_id`  out  8  id of the task currently dispatched; 0 when none.
- `busy`  out  1  high in every state except IDLE and SCAN.
- `ack_err`  out  1  sticky; set on Execute acknowledge timeout.
- `dispatch_count`  out  16  number of acknowledged slices, wraps at 0xFFFF→0.

## Operation
- Opcodes: Execute = 4'b0111, Finish = 4'b1111. `out_op` = 16'h0000 in every cycle outside ISSUE and FINISH; tasks treat that value as no-op.
- FSM states: IDLE, SCAN, ISSUE, ACK, RUN, FINISH.
- IDLE: if `enable`=1, clear the best-candidate registers and the scan index, then go to SCAN.
- SCAN: read one slot per cycle, indices 0..N_TASKS-1.
  - A slot is a candidate if id≠0.
  - It replaces the best if no best exists yet, or if its priority is strictly greater than the best's (unsigned 8-bit).
  - Ties go to the lower index.
  - After the last index: if a best exists, go to ISSUE; otherwise go to IDLE.
- ISSUE: drive `out_op` = {4'h0, best_id[3:0], 4'b0111, 4'h0} for exactly one cycle, load `cur_id`, clear the wait counter, go to ACK.
- ACK: if `in_exe_flags[best_idx]`=1, go to RUN with the slice counter cleared. Otherwise increment the wait counter; when it reaches ACK_TIMEOUT, set `ack_err` and go to FINISH.
- RUN: count cycles; after SLICE_CYCLES cycles go to FINISH.
- FINISH: drive `out_op` = {4'h0, best_id[3:0], 4'b1111, 4'h0} for one cycle.
  - Increment `dispatch_count` only if the slice was acknowledged.
  - Clear `cur_id` and go to IDLE.
- `enable` is sampled only in IDLE.
- Slot words that change during SCAN are used as sampled at their own scan cycle.
- Slot words that change after SCAN are ignored until the next scan.
- `ack_err` clears only on `RST`.

## Timing
- Reset values:
  - state = IDLE;
  - `out_op` = 0, `cur_id` = 0, `busy` = 0, `ack_err` = 0, `dispatch_count` = 0;
  - all counters = 0.
- Reset acts asynchronously: `out_op` returns to 0 immediately, even in the middle of ISSUE, RUN or FINISH.
- `out_op` and `cur_id` are registered outputs.
- Latency from the IDLE cycle with `enable`=1 to Execute on `out_op`: N_TASKS+1 cycles (1 IDLE + N_TASKS SCAN).
- The earliest `exe_flag` the block can see is in the first ACK cycle (the cycle after ISSUE). An acknowledge at wait count w means RUN starts the next cycle.
- Full slice with immediate acknowledge: ISSUE(1) + ACK(1) + RUN(SLICE_CYCLES) + FINISH(1), then IDLE(1). The next Execute follows N_TASKS+1 cycles after that IDLE.
- Timeout path: ISSUE, then ACK_TIMEOUT ACK cycles, then FINISH. `ack_err` goes high in the cycle FINISH is entered.
- No valid slot: SCAN→IDLE with no op driven; a rescan starts on the next cycle while `enable`=1.
- `dispatch_count` wraps from 0xFFFF to 0x0000 without a flag.

## Test plan
- Reset, then `enable`=1 with N_TASKS=8, slot 3 = 0x0507 and slot 6 = 0x0203 → `out_op`=0x0570 in cycle 10 after enable, `cur_id`=0x05, `busy`=1.
- Slots 1 = 0x0404 and 5 = 0x0604 (tie) → Execute targets id 4 (`out_op`=0x0470).
- Drive `in_exe_flags[3]` high one cycle after ISSUE, SLICE_CYCLES=20 → `out_op`=0x05F0 exactly 21 cycles after ACK entry; `dispatch_count`=1; `cur_id`=0 afterwards.
- Never raise the flag, ACK_TIMEOUT=16 → `ack_err`=1 after 16 ACK cycles, Finish 0x05F0 issued, `dispatch_count` unchanged.
- All slots zero → `out_op` stays 0x0000 and `busy`=0 for 100 cycles.
- Assert `RST` mid-RUN → `out_op`=0, `cur_id`=0, state IDLE in the same cycle; after release, a fresh scan starts; `ack_err` and `dispatch_count` read 0.
